// File: rtl/fetch_pkg.sv
// Shared types and limits for the fetch sequencing controller.
// State encoding, default widths and flush-length bound.
package fetch_pkg;

    localparam int ADDR_W_DEF    = 16;
    localparam int REG_AW_DEF    = 5;
    localparam int FLUSH_CYC_MAX = 3;
    localparam int CNT_W         = 2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        HALT     = 2'd3
    } fstate_e;

endpackage

// File: rtl/fetch_ctrl_hazard_detect.sv
// Load-use hazard term between the ID instruction and a load in EX.
// Purely combinational; also shared with the forwarding unit.
module hazard_detect
    import fetch_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_mem_read_i,
    output logic              lu_o
);

    logic rd_nz;
    logic rs_hit;
    logic rt_hit;

    // Register zero is never a real producer, so it cannot create a hazard.
    always_comb begin
        rd_nz  = (ex_rd_i != '0);
        rs_hit = (ex_rd_i == id_rs_i);
        rt_hit = id_uses_rt_i & (ex_rd_i == id_rt_i);
        lu_o   = ex_mem_read_i & rd_nz & (rs_hit | rt_hit);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencing FSM: load-use stall, jump/branch redirect, halt.
// Optional FETCH_CTRL_PERF_EN adds saturating stall/redirect counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int FLUSH_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt_req,
    input  logic              resume,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_redirect_cnt,
`endif
    output logic              stall,
    output logic              stall_pm,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              halted
);

    localparam int FC = (FLUSH_CYC > FLUSH_CYC_MAX) ? FLUSH_CYC_MAX : FLUSH_CYC;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    fstate_e           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_pm_q;
    logic [ADDR_W-1:0] jmp_loc_q;
    logic [ADDR_W-1:0] tgt;
    logic              lu;
    logic              redir;

    hazard_detect #(.REG_AW(REG_AW)) u_hz (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .ex_rd_i       (ex_rd),
        .ex_mem_read_i (ex_mem_read),
        .lu_o          (lu)
    );

    // Next state and control outputs under br > jmp > halt > lu priority.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        pc_mux_sel  = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        tgt         = jmp_loc_q;
        redir       = 1'b0;
        if (br_taken) begin
            redir       = 1'b1;
            tgt         = br_target;
            flush_id_ex = 1'b1;
        end else if (jmp_req && state_q != HALT) begin
            redir = 1'b1;
            tgt   = jmp_target;
        end
        if (redir) begin
            pc_mux_sel  = 1'b1;
            flush_if_id = 1'b1;
            cnt_d       = CNT_LOAD;
            state_d     = (FC > 1) ? FLUSH : RUN;
        end else begin
            unique case (state_q)
                RUN, LU_STALL: begin
                    if (halt_req) begin
                        stall       = 1'b1;
                        flush_id_ex = 1'b1;
                        state_d     = HALT;
                    end else if (lu) begin
                        stall       = 1'b1;
                        flush_id_ex = 1'b1;
                        state_d     = LU_STALL;
                    end else begin
                        state_d = RUN;
                    end
                end
                FLUSH: begin
                    flush_if_id = 1'b1;
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                HALT: begin
                    stall       = 1'b1;
                    flush_id_ex = 1'b1;
                    if (resume) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
        // Reset forces every control low even before the first edge.
        if (!reset) begin
            stall       = 1'b0;
            pc_mux_sel  = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
        jmp_loc  = pc_mux_sel ? tgt : jmp_loc_q;
        stall_pm = stall_pm_q;
        halted   = (state_q == HALT);
    end

    // State, flush countdown, replay select and held redirect address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            stall_pm_q <= 1'b0;
            jmp_loc_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stall_pm_q <= stall;
            jmp_loc_q  <= jmp_loc;
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_redir_q;

    // Saturating event counters for stall and redirect cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_redir_q <= '0;
        end else begin
            if (stall && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
            if (pc_mux_sel && perf_redir_q != '1)
                perf_redir_q <= perf_redir_q + 32'd1;
        end
    end

    assign perf_stall_cnt    = perf_stall_q;
    assign perf_redirect_cnt = perf_redir_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with FLUSH_CYC=1 (a_*) and FLUSH_CYC=3 (b_*).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_mem_read;
    logic        jmp_req, br_taken, halt_req, resume;
    logic [15:0] jmp_target, br_target;

    logic        a_stall, a_stall_pm, a_pc, a_fif, a_fie, a_halted;
    logic [15:0] a_loc;
    logic        b_stall, b_stall_pm, b_pc, b_fif, b_fie, b_halted;
    logic [15:0] b_loc;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] a_ps, a_pr, b_ps, b_pr;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.FLUSH_CYC(1)) dut_a (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .jmp_req(jmp_req), .jmp_target(jmp_target),
        .br_taken(br_taken), .br_target(br_target),
        .halt_req(halt_req), .resume(resume),
`ifdef FETCH_CTRL_PERF_EN
        .perf_stall_cnt(a_ps), .perf_redirect_cnt(a_pr),
`endif
        .stall(a_stall), .stall_pm(a_stall_pm), .pc_mux_sel(a_pc),
        .jmp_loc(a_loc), .flush_if_id(a_fif), .flush_id_ex(a_fie),
        .halted(a_halted)
    );

    fetch_ctrl #(.FLUSH_CYC(3)) dut_b (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .jmp_req(jmp_req), .jmp_target(jmp_target),
        .br_taken(br_taken), .br_target(br_target),
        .halt_req(halt_req), .resume(resume),
`ifdef FETCH_CTRL_PERF_EN
        .perf_stall_cnt(b_ps), .perf_redirect_cnt(b_pr),
`endif
        .stall(b_stall), .stall_pm(b_stall_pm), .pc_mux_sel(b_pc),
        .jmp_loc(b_loc), .flush_if_id(b_fif), .flush_id_ex(b_fie),
        .halted(b_halted)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        jmp_req = 1'b0; br_taken = 1'b0;
        halt_req = 1'b0; resume = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        reset = 1'b0;
        jmp_target = '0;
        br_target = '0;
        idle();

        // reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            id_rs = 5'($urandom); id_rt = 5'($urandom);
            ex_rd = 5'($urandom); id_uses_rt = 1'($urandom);
            ex_mem_read = 1'($urandom); jmp_req = 1'($urandom);
            br_taken = 1'($urandom); halt_req = 1'($urandom);
            resume = 1'($urandom);
            jmp_target = 16'($urandom); br_target = 16'($urandom);
            #1;
            chk1("rst_stall", a_stall, 1'b0);
            chk1("rst_pc", a_pc, 1'b0);
            chk1("rst_fif", a_fif, 1'b0);
            chk1("rst_fie", a_fie, 1'b0);
            chk1("rst_halted", a_halted, 1'b0);
            chk1("rst_stall_pm", a_stall_pm, 1'b0);
            chk16("rst_loc", a_loc, 16'h0000);
        end

        step(); reset = 1'b1; #1;
        chk1("run_stall", a_stall, 1'b0);
        chk1("run_halted", a_halted, 1'b0);

        // load-use on rs
        step(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; #1;
        chk1("lu_stall", a_stall, 1'b1);
        chk1("lu_fie", a_fie, 1'b1);
        chk1("lu_pm_pre", a_stall_pm, 1'b0);
        step(); #1;
        chk1("lu_pm", a_stall_pm, 1'b1);
        chk1("lu_stall_next", a_stall, 1'b0);
        step(); #1;
        chk1("lu_pm_clear", a_stall_pm, 1'b0);

        // ex_rd == 0 never stalls
        step(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; #1;
        chk1("lu_r0", a_stall, 1'b0);
        // rt path
        step(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = 5'd3;
        id_rt = 5'd7; id_uses_rt = 1'b1; #1;
        chk1("lu_rt", a_stall, 1'b1);
        step(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs = 5'd3;
        id_rt = 5'd7; id_uses_rt = 1'b0; #1;
        chk1("lu_rt_unused", a_stall, 1'b0);

        // branch beats jump and hazard
        step(); br_taken = 1'b1; br_target = 16'h0040;
        jmp_req = 1'b1; jmp_target = 16'h0100;
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; #1;
        chk1("br_pc", a_pc, 1'b1);
        chk16("br_loc", a_loc, 16'h0040);
        chk1("br_fif", a_fif, 1'b1);
        chk1("br_fie", a_fie, 1'b1);
        chk1("br_stall", a_stall, 1'b0);
        step(); #1;
        chk1("br_pc_after", a_pc, 1'b0);
        chk16("br_loc_hold", a_loc, 16'h0040);
        chk1("br_fif_after", a_fif, 1'b0);

        // plain jump
        step(); jmp_req = 1'b1; jmp_target = 16'h0100; #1;
        chk1("jmp_pc", a_pc, 1'b1);
        chk16("jmp_loc", a_loc, 16'h0100);
        chk1("jmp_fie", a_fie, 1'b0);
        step(); step(); step(); #1;
        chk1("b_idle_fif", b_fif, 1'b0);

        // FLUSH_CYC=3 sequence
        step(); jmp_req = 1'b1; jmp_target = 16'h0020; #1;
        chk1("f3_pc0", b_pc, 1'b1);
        chk1("f3_fif0", b_fif, 1'b1);
        chk16("f3_loc", b_loc, 16'h0020);
        step(); #1;
        chk1("f3_pc1", b_pc, 1'b0);
        chk1("f3_fif1", b_fif, 1'b1);
        chk1("f1_fif1", a_fif, 1'b0);
        step(); #1;
        chk1("f3_pc2", b_pc, 1'b0);
        chk1("f3_fif2", b_fif, 1'b1);
        step(); #1;
        chk1("f3_fif3", b_fif, 1'b0);
        chk16("f3_loc_hold", b_loc, 16'h0020);

        // halt / resume
        step(); halt_req = 1'b1; #1;
        chk1("h_req_stall", a_stall, 1'b1);
        chk1("h_req_fie", a_fie, 1'b1);
        chk1("h_req_halted", a_halted, 1'b0);
        step(); #1;
        chk1("h_halted", a_halted, 1'b1);
        chk1("h_stall", a_stall, 1'b1);
        chk1("h_pm", a_stall_pm, 1'b1);
        step(); jmp_req = 1'b1; jmp_target = 16'h0200; #1;
        chk1("h_jmp_pc", a_pc, 1'b0);
        chk16("h_jmp_loc", a_loc, 16'h0020);
        chk1("h_jmp_halted", a_halted, 1'b1);
        step(); resume = 1'b1; #1;
        chk1("h_res_stall", a_stall, 1'b1);
        step(); #1;
        chk1("h_after_halted", a_halted, 1'b0);
        chk1("h_after_stall", a_stall, 1'b0);
        chk1("h_after_pm", a_stall_pm, 1'b1);
        step(); resume = 1'b1; #1;
        chk1("h_pm_clear", a_stall_pm, 1'b0);
        chk1("res_ignored", a_halted, 1'b0);
        step(); #1;
        chk1("res_ignored_next", a_halted, 1'b0);

        // async reset in HALT
        step(); halt_req = 1'b1;
        step(); #1;
        chk1("ar_pre_halted", a_halted, 1'b1);
        #2 reset = 1'b0; #1;
        chk1("ar_halted", a_halted, 1'b0);
        chk1("ar_stall", a_stall, 1'b0);
        chk1("ar_pm", a_stall_pm, 1'b0);
        chk1("ar_fie", a_fie, 1'b0);
        step(); reset = 1'b1; #1;
        chk1("ar_run_halted", a_halted, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
